// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a circular TX FIFO.
// TXDATA at BASE+0 (write-only), STATUS at BASE+4: {count, overflow, busy, empty, full}.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_EN,
    input  logic        read_EN,
    input  logic [1:0]  data_type,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      count4;
    logic            overflow;

    logic sel, txdata_sel, status_sel;
    logic full, empty, busy, bit_end;
    logic push_req, push, pop, ovf_clr;
    logic unused_ok;

    assign sel        = (address[31:3] == BASE_ADDR[31:3]);
    assign txdata_sel = sel && !address[2];
    assign status_sel = sel && address[2];

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state_q != IDLE);
    assign count4  = 4'(count);
    assign bit_end = (bit_cnt_q == BW'(CLKS_PER_BIT - 1));

    // A full FIFO still accepts a store when the serializer frees a slot on the same edge.
    assign pop      = (state_q == IDLE) && !empty;
    assign push_req = write_EN && txdata_sel;
    assign push     = push_req && (!full || pop);
    assign ovf_clr  = write_EN && status_sel && write_data[3];

    assign unused_ok = ^{data_type, address[1:0], write_data[31:8]};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (ovf_clr)             overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // tx is registered alongside the state so the line only moves on a clock edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                bit_cnt_d = '0;
                if (!empty) begin
                    state_d = START;
                    shift_d = mem[rd_ptr];
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_data = 32'h0;
        if (read_EN && status_sel)
            read_data = {24'h0, count4, overflow, busy, empty, full};
    end

    assign tx  = tx_q;
    assign irq = empty && (state_q == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-position model of the serial line and FIFO, compared every
// cycle, plus directed literal checks on frame shape, STATUS words and reset behaviour.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        write_EN = 1'b0;
    logic        read_EN = 1'b0;
    logic [1:0]  data_type = 2'b00;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        tx, irq;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n), .write_EN(write_EN), .read_EN(read_EN),
        .data_type(data_type), .address(address), .write_data(write_data),
        .read_data(read_data), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue; serializer as a position within a 10-bit frame (-1 = idle).
    logic [7:0] q[$];
    int         pos = -1;
    logic [7:0] cur = 8'h0;
    logic       ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            pos = -1;
            ovf = 1'b0;
        end else begin
            logic popped, was_full, sel;
            was_full = (q.size() == DEPTH);
            sel      = (address[31:3] == BASE[31:3]);
            popped   = 1'b0;
            if (pos < 0) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    pos = 0;
                    popped = 1'b1;
                end
            end else begin
                pos = pos + 1;
                if (pos == 10 * CPB) pos = -1;
            end
            if (write_EN && sel && !address[2]) begin
                if (!was_full || popped) q.push_back(write_data[7:0]);
                else ovf = 1'b1;
            end
            if (write_EN && sel && address[2] && write_data[3]) ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int b;
        if (pos < 0) return 1'b1;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [3:0] n;
        n = 4'(q.size());
        if (read_EN && address[31:3] == BASE[31:3] && address[2])
            return {24'h0, n, ovf, pos >= 0, q.size() == 0, q.size() == DEPTH};
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_tx", {31'h0, tx}, {31'h0, exp_tx()});
            chk("model_irq", {31'h0, irq}, {31'h0, (pos < 0) && (q.size() == 0)});
            chk("model_read_data", read_data, exp_rd());
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        write_EN = 1'b1; address = a; write_data = d;
        @(posedge clk); #1;
        write_EN = 1'b0;
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        read_EN = 1'b1; address = a;
        #2 chk(name, read_data, exp);
        @(posedge clk); #1;
        read_EN = 1'b0;
    endtask

    task automatic wait_irq(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (irq) begin ok = 1'b1; break; end
        end
        chk("irq_wait", {31'h0, ok}, 32'h1);
        @(posedge clk); #1;
    endtask

    logic [40:0] w;
    logic        irq40, irq41, found;
    logic        exp55 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          glitches;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_irq", {31'h0, irq}, 32'h1);
        read_EN = 1'b1; address = BASE + 32'h4;
        #1 chk("reset_status", read_data, 32'h2);
        read_EN = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 0x55 frame; first store lands on the first edge after release.
        store(BASE, 32'h55);
        for (int c = 0; c <= 41; c++) begin
            @(negedge clk);
            if (c <= 40) w[c] = tx;
            if (c == 40) irq40 = irq;
            if (c == 41) irq41 = irq;
        end
        chk("idle_before_start", {31'h0, w[0]}, 32'h1);
        for (int b = 0; b < 10; b++)
            chk("frame55_bit", {28'h0, w[1 + 4*b +: 4]}, {28'h0, {4{exp55[b]}}});
        chk("irq_low_in_stop", {31'h0, irq40}, 32'h0);
        chk("irq_high_after_41", {31'h0, irq41}, 32'h1);
        @(posedge clk); #1;

        // Nine back-to-back stores: first is popped immediately, so FIFO ends exactly full.
        data_type = 2'b01;
        for (int i = 1; i <= 9; i++) store(BASE, i);
        data_type = 2'b00;
        read_chk(BASE + 32'h4, 32'h85, "status_nine");
        wait_irq(1000);

        // Ten stores: tenth dropped, sticky overflow, then cleared through STATUS.
        for (int i = 0; i < 10; i++) store(BASE, 32'h11 + i);
        read_chk(BASE + 32'h4, 32'h8D, "status_overflow");
        store(BASE + 32'h4, 32'h8);
        read_chk(BASE + 32'h4, 32'h85, "status_ovf_cleared");

        // Store into a full FIFO on the serializer's pop edge.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            read_EN = 1'b1; address = BASE + 32'h4;
            #1;
            if (read_data[2] == 1'b0 && read_data[0] == 1'b1) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        read_EN = 1'b0;
        chk("found_pop_edge", {31'h0, found}, 32'h1);
        store(BASE, 32'hA5);
        read_chk(BASE + 32'h4, 32'h85, "status_same_edge");
        wait_irq(1000);

        // Reset in the middle of data bit 3 of a 0x00 frame.
        store(BASE, 32'h00);
        repeat (18) @(posedge clk);
        #2 chk("tx_before_reset", {31'h0, tx}, 32'h0);
        #1 rst_n = 1'b0;
        #1 chk("tx_on_reset", {31'h0, tx}, 32'h1);
        chk("irq_on_reset", {31'h0, irq}, 32'h1);
        @(posedge clk); #1 rst_n = 1'b1;
        read_chk(BASE + 32'h4, 32'h02, "status_after_reset");
        glitches = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) glitches++;
        end
        chk("no_resume_after_reset", glitches, 0);
        @(posedge clk); #1;

        // Decode and access-enable checks.
        read_chk(BASE + 32'h8, 32'h0, "read_unselected");
        read_chk(BASE, 32'h0, "read_txdata");
        read_chk(BASE + 32'h7, 32'h02, "read_byte_offset");
        address = BASE + 32'h4; read_EN = 1'b0;
        #1 chk("read_en_low", read_data, 32'h0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
- REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: byte address of register block (TXDATA at +0x0, STATUS at +0x4).
- REQ-002 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200).
- REQ-003 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries (power of two, 2..16).
- REQ-004 clk  input  1  rising-edge system clock.
- REQ-005 reset  input  1  asynchronous, active-low reset.
- REQ-006 write_EN  input  1  CPU data-bus store strobe.
- REQ-007 read_EN  input  1  CPU data-bus load strobe.
- REQ-008 data_type  input  2  access size from CPU; accepted but ignored, all accesses treated as word.
- REQ-009 address  input  32  CPU data-bus byte address.
- REQ-010 write_data  input  32  CPU store data.
- REQ-011 read_data  output  32  load data; 32'h0 when not selected.
- REQ-012 tx  output  1  serial line, idle high.
- REQ-013 irq  output  1  high while FIFO empty and serializer idle.

Function
- REQ-014 Block SHALL be selected when address[31:3] equals BASE_ADDR[31:3]; address[1:0] SHALL be ignored.
- REQ-015 Store to TXDATA with write_EN high SHALL push write_data[7:0] into FIFO on that rising clk edge.
- REQ-016 Store to TXDATA while FIFO full SHALL discard the byte and set sticky STATUS.overflow, unless a pop occurs on the same edge, in which case the push SHALL be accepted.
- REQ-017 Store to STATUS with write_data[3]=1 SHALL clear overflow; other STATUS bits read-only.
- REQ-018 read_data SHALL be combinational: read_EN and STATUS selected -> {24'h0, count[3:0], overflow, busy, empty, full}; TXDATA selected -> 32'h0; otherwise 32'h0.
- REQ-019 count SHALL equal current FIFO occupancy, 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0), busy = (FSM != IDLE).
- REQ-020 FIFO SHALL be circular with read/write pointers wrapping modulo FIFO_DEPTH; byte order preserved.
- REQ-021 FSM states SHALL be IDLE, START, DATA, STOP.
- REQ-022 IDLE with FIFO non-empty SHALL pop head byte into shift register on the next edge and enter START; tx driven from state register only (no combinational glitch).
- REQ-023 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
- REQ-024 DATA SHALL drive 8 bits LSB first, each exactly CLKS_PER_BIT cycles, then enter STOP.
- REQ-025 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, then enter IDLE; frame length 10*CLKS_PER_BIT cycles.
- REQ-026 Back-to-back: IDLE with non-empty FIFO SHALL pop in the first IDLE cycle, giving exactly one idle-high cycle between frames.
- REQ-027 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and reset on every state or bit transition.
- REQ-028 Push and pop on the same edge SHALL leave count unchanged.

Reset
- REQ-029 reset low SHALL immediately force: FSM IDLE, tx=1, FIFO empty (pointers and count 0), overflow=0, counters 0, irq=1.
- REQ-030 reset asserted mid-frame SHALL abort the frame; no partial byte resumes after release.
- REQ-031 After reset deasserts, first store SHALL be accepted on the first subsequent rising edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
- REQ-032 Store 0x55 to 0x1000_0000 -> tx: 1 idle cycle, then 0 for 4 cycles, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 1 for 4 cycles; irq high again after 41 cycles.
- REQ-033 Nine stores 0x01..0x09 in consecutive cycles -> first byte popped, so no overflow; STATUS read shows count=8, full=1; bytes appear on tx in order 0x01..0x09.
- REQ-034 Ten consecutive stores -> tenth dropped, STATUS bit3=1; store 0x8 to 0x1000_0004 -> bit3=0.
- REQ-035 Store to FIFO-full while FSM pops on same edge -> byte accepted, count stays 8, overflow stays 0.
- REQ-036 Assert reset during DATA bit 3 -> tx=1 same cycle, STATUS reads 32'h02 after release, no further transitions on tx.
- REQ-037 Load from 0x1000_0008 or with read_EN low -> read_data=32'h0.
